// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the pipeline-stage registers.
//               Holds the decode/execute payload field widths, the derived
//               bundle width and the skid-buffer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Decode/execute payload field widths
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;
    localparam int REG_W    = 32;
    localparam int RADDR_W  = 5;

    // aluop + alusel + reg1 + reg2 + imm + waddr + we
    localparam int ID_EX_W  = ALUOP_W + ALUSEL_W + 3 * REG_W + RADDR_W + 1;

    // Skid-buffer occupancy: no entry / main only / main + skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments by one when i_inc is high and
//               sticks at its all-ones value instead of wrapping.
// Ports       : clk      clock
//               rst      synchronous reset, active-low (clears the count)
//               i_inc    increment request for this cycle
//               o_count  current count
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Parametrised pipeline-stage register carrying an opaque
//               payload with valid/ready handshake, synchronous flush and a
//               saturating stall-cycle counter. SKID=0 is a single register
//               with combinational in_ready; SKID=1 is a two-entry skid
//               buffer whose in_ready is a flop.
// Ports       : clk        clock
//               rst        synchronous reset, active-low
//               in_valid   upstream payload valid
//               in_ready   stage can accept this cycle
//               in_data    upstream payload
//               flush      kill all held entries
//               out_valid  downstream payload valid
//               out_ready  downstream accepts
//               out_data   held payload (all-zero when invalid = NOP)
//               stall_cnt  cycles with out_valid=1 and out_ready=0
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_W,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_stall;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign w_stall    = out_valid & ~out_ready;

    if (SKID == 0) begin : g_reg
        logic              r_valid;
        logic [DATA_W-1:0] r_data;

        // A full register can still accept when the held word leaves
        // in the same cycle.
        assign in_ready = ~r_valid | out_ready;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_in_xfer) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
            end else if (w_out_xfer) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end
        end

        assign out_valid = r_valid;
        assign out_data  = r_data;
    end else begin : g_skid
        skid_state_t       r_state;
        skid_state_t       w_state_nxt;
        logic [DATA_W-1:0] r_main;
        logic [DATA_W-1:0] r_skid;
        logic [DATA_W-1:0] w_main_nxt;
        logic [DATA_W-1:0] w_skid_nxt;
        logic              r_in_ready;

        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
            if (flush) begin
                w_state_nxt = EMPTY;
                w_main_nxt  = '0;
                w_skid_nxt  = '0;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_in_xfer) begin
                            w_state_nxt = MAIN;
                            w_main_nxt  = in_data;
                        end
                    end
                    MAIN: begin
                        if (w_in_xfer && w_out_xfer) begin
                            w_main_nxt  = in_data;
                        end else if (w_out_xfer) begin
                            // Leaving the main entry zeroed keeps the bubble a NOP
                            w_state_nxt = EMPTY;
                            w_main_nxt  = '0;
                        end else if (w_in_xfer) begin
                            w_state_nxt = FULL;
                            w_skid_nxt  = in_data;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only the output side moves
                        if (w_out_xfer) begin
                            w_state_nxt = MAIN;
                            w_main_nxt  = r_skid;
                            w_skid_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = '0;
                        w_skid_nxt  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state    <= EMPTY;
                r_main     <= '0;
                r_skid     <= '0;
                r_in_ready <= 1'b1;
            end else begin
                r_state    <= w_state_nxt;
                r_main     <= w_main_nxt;
                r_skid     <= w_skid_nxt;
                // Registered from next state: no out_ready -> in_ready path
                r_in_ready <= (w_state_nxt != FULL);
            end
        end

        assign in_ready  = r_in_ready;
        assign out_valid = (r_state != EMPTY);
        assign out_data  = r_main;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall),
        .o_count (stall_cnt)
    );

endmodule
`default_nettype wire
